// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU data port and the data memory responder.
// The CPU drives through the master modport; the responder connects to the slave modport.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with a fixed access latency.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a request (req_ready = 1)
// WAIT  | request latched, counting down the remaining latency
// RESP  | response presented (rsp_valid = 1) until rsp_ready
//
// The array access happens on the edge that enters RESP. With LATENCY = 1
// that edge is the acceptance edge itself, so the request is taken straight
// from the bus instead of the latched copy.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_responder_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(LATENCY + 1);
    localparam bit LAT1 = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    // Select the request being executed and decide whether this edge enters RESP.
    always_comb begin
        accept     = (state == IDLE) && bus.req_valid && bus.req_ready;
        enter_resp = !rst && ((accept && LAT1) || ((state == WAIT) && (cnt == CW'(1))));
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);
        acc_idx = acc_addr[AW+1:2];
    end

    // Byte-lane store into the array; never reset, and suppressed on error or reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_be        <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we        <= bus.req_we;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        lat_be        <= bus.req_be;
                        bus.req_ready <= 1'b0;
                        if (LAT1) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase

            // Capture the response on the edge entering RESP; it then holds through RESP.
            if (enter_resp) begin
                bus.rsp_err   <= acc_err;
                bus.rsp_rdata <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH 1024, LATENCY 2).
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_be    = 4'd0;
    endtask

    // One complete transaction; hold = cycles rsp_ready is kept low in RESP.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        logic [31:0] rd0;
        @(negedge clk);
        chk({tag, "/idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = (hold == 0);
        @(posedge clk);
        #1 idle_bus();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk({tag, "/valid_lat"}, {31'd0, bus.rsp_valid}, {31'd0, (k == LAT)});
            chk({tag, "/ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
        end
        chk({tag, "/rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, "/err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        rd0 = bus.rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            chk({tag, "/hold_rdata"}, bus.rsp_rdata, rd0);
            chk({tag, "/hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/after_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "/after_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        idle_bus();
        bus.rsp_ready = 1'b1;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst/req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst/rsp_err",   {31'd0, bus.rsp_err}, 32'd0);

        // Full store then load
        txn("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 0);
        txn("ld_full", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

        // Partial store (low two lanes)
        txn("st_part", 1'b1, 32'h10, 32'h00001234, 4'h3, 32'd0, 1'b0, 0);
        txn("ld_part", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD1234, 1'b0, 0);

        // Single top lane
        txn("st_lane3", 1'b1, 32'h10, 32'h77FFFFFF, 4'h8, 32'd0, 1'b0, 0);
        txn("ld_lane3", 1'b0, 32'h10, 32'd0, 4'h0, 32'h77AD1234, 1'b0, 0);

        // Zero byte enables: normal response, memory unchanged
        txn("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 0);
        txn("ld_be0", 1'b0, 32'h10, 32'd0, 4'h0, 32'h77AD1234, 1'b0, 0);

        // Misaligned load
        txn("ld_misal", 1'b0, 32'h13, 32'd0, 4'h0, 32'd0, 1'b1, 0);

        // Out-of-range store must not alias onto word 0
        txn("st_w0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, 0);
        txn("st_oor", 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'd0, 1'b1, 0);
        txn("ld_w0", 1'b0, 32'h0, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, 0);
        txn("ld_oor_hi", 1'b0, 32'h8000_0000, 32'd0, 4'h0, 32'd0, 1'b1, 0);

        // Highest valid word
        txn("st_top", 1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0, 0);
        txn("ld_top", 1'b0, 32'hFFC, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);

        // Backpressure: rsp_ready low for 5 cycles in RESP
        txn("ld_hold", 1'b0, 32'h10, 32'd0, 4'h0, 32'h77AD1234, 1'b0, 5);

        // Reset during WAIT discards the store
        txn("st_20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'd0, 1'b0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h00000055;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1 idle_bus();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_wait/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rst_wait/req_ready", {31'd0, bus.req_ready}, 32'd1);
        end
        txn("ld_20", 1'b0, 32'h20, 32'd0, 4'h0, 32'h11223344, 1'b0, 0);

        // Reset during RESP drops the response
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        @(posedge clk);
        #1 idle_bus();
        repeat (LAT) @(negedge clk);
        chk("rst_resp/pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rst_resp/pre_rdata", bus.rsp_rdata, 32'hCAFEF00D);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_resp/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_resp/req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp/rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_resp/rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        bus.rsp_ready = 1'b1;

        // Reset does not clear the array
        txn("ld_after_rst", 1'b0, 32'hFFC, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the array (power of two, at least 4).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response valid (at least 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning the CPU presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit, where 1 is a store and 0 is a load.
REQ-008 The block SHALL have port req_addr, input, 32 bits, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits, the store data.
REQ-010 The block SHALL have port req_be, input, 4 bits, the store byte enables, with bit i covering bits 8i+7 to 8i of the word.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, meaning a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit, meaning the CPU takes the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits, the load data; it SHALL be 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1 bit, meaning the request was misaligned or out of range.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP, and a latency counter sized to hold LATENCY.
REQ-016 req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted on an edge where req_valid and req_ready are both 1.
  - On acceptance the block SHALL latch req_we, req_addr, req_wdata and req_be.
REQ-018 On acceptance the next state SHALL be WAIT with the counter loaded to LATENCY-1; if LATENCY equals 1, the next state SHALL be RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; when the counter is 1, the next state SHALL be RESP.
  - rsp_valid SHALL therefore first be seen LATENCY cycles after the acceptance edge.
REQ-020 The word index SHALL be latched addr[log2(DEPTH)+1:2].
REQ-021 rsp_err SHALL be 1 if latched addr[1:0] is nonzero or any latched address bit at or above log2(DEPTH)+2 is set.
REQ-022 On the edge entering RESP, the block SHALL perform the access.
  - Store without error: write only the enabled byte lanes; other lanes keep their value.
  - Load without error: register the full word into rsp_rdata.
  - Error: no array write, and rsp_rdata SHALL be 0.
REQ-023 rsp_rdata and rsp_err SHALL hold stable throughout RESP.
REQ-024 In RESP, when rsp_ready is 1, the next state SHALL be IDLE; otherwise RESP SHALL hold indefinitely.
REQ-025 Only one request SHALL be outstanding at a time.
  - req_ready SHALL return to 1 on the cycle after the response handshake.
  - Minimum request spacing is therefore LATENCY+1 cycles.
REQ-026 req_valid SHALL be ignored in WAIT and RESP, and no request SHALL be queued.
REQ-027 A store with req_be of 0 SHALL complete with a normal response (rsp_err 0) and leave memory unchanged.
REQ-028 The block SHALL not enforce ordering beyond single outstanding; a load following a store to the same word SHALL return the stored data.

Reset
REQ-029 While rst is 1 at an edge, the next state SHALL be IDLE and the counter SHALL be 0.
  - Next-cycle outputs: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 Reset SHALL NOT clear the memory array.
REQ-031 A store in WAIT when rst is asserted SHALL be discarded, with no array write.
REQ-032 A response pending in RESP when rst is asserted SHALL be dropped.

Verification
REQ-033 Assert rst for 2 cycles, then release -> req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-034 With LATENCY 2, store addr 0x10, data 0xDEADBEEF, be 0xF; hold rsp_ready 1 -> rsp_valid exactly 2 cycles after acceptance with err 0. Then load 0x10 -> rdata 0xDEADBEEF.
REQ-035 Store addr 0x10, data 0x00001234, be 0x3 onto 0xDEADBEEF; then load 0x10 -> rdata 0xDEAD1234.
REQ-036 Load addr 0x13 -> err 1, rdata 0. Store addr 0x1000 with DEPTH 1024 -> err 1, and a load of 0x0 is unchanged.
REQ-037 Hold rsp_ready 0 for 5 cycles during RESP -> rsp_valid and rdata stay stable and req_ready stays 0; after the handshake, req_ready is 1 the next cycle.
REQ-038 Issue a store of 0x55 to 0x20, then pulse rst while in WAIT -> rsp_valid never asserts, and a later load of 0x20 returns the prior contents.
